// File: rtl/regfile_ext_sb.sv
// MIPS GPR file: NRP combinational read ports, load-extension write-back, link write,
// optional write-to-read bypass and a load scoreboard driving stall.
module regfile_ext_sb #(
    parameter int unsigned DW     = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned NRP    = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [2:0]        wmode,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [1:0]        byte_off,
    input  logic [DW-1:0]     pc,
    input  logic [NRP*AW-1:0] raddr,
    output logic [NRP*DW-1:0] rdata,
    input  logic              issue_ld,
    input  logic [AW-1:0]     ld_rd,
    output logic [NREG-1:0]   busy,
    output logic              stall,
    output logic              misalign
);

    localparam logic [2:0] ModeWord = 3'd0;
    localparam logic [2:0] ModeLb   = 3'd1;
    localparam logic [2:0] ModeLbu  = 3'd2;
    localparam logic [2:0] ModeLh   = 3'd3;
    localparam logic [2:0] ModeLhu  = 3'd4;
    localparam logic [2:0] ModeLink = 3'd5;

    logic [DW-1:0]   regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic            misalign_q;

    logic [7:0]    wbyte;
    logic [15:0]   whalf;
    logic [DW-1:0] wv;
    logic          legal;
    logic          misal;
    logic          do_write;

    assign wbyte = wdata[8*byte_off +: 8];
    assign whalf = wdata[16*byte_off[1] +: 16];

    // Extended write value; reserved modes stay illegal without flagging misalign.
    always_comb begin
        wv    = '0;
        legal = 1'b0;
        misal = 1'b0;
        case (wmode)
            ModeWord: begin
                wv    = wdata;
                legal = (byte_off == 2'd0);
                misal = !legal;
            end
            ModeLb: begin
                wv    = {{(DW-8){wbyte[7]}}, wbyte};
                legal = 1'b1;
            end
            ModeLbu: begin
                wv    = {{(DW-8){1'b0}}, wbyte};
                legal = 1'b1;
            end
            ModeLh: begin
                wv    = {{(DW-16){whalf[15]}}, whalf};
                legal = !byte_off[0];
                misal = byte_off[0];
            end
            ModeLhu: begin
                wv    = {{(DW-16){1'b0}}, whalf};
                legal = !byte_off[0];
                misal = byte_off[0];
            end
            ModeLink: begin
                wv    = pc + DW'(4);
                legal = 1'b1;
            end
            default: ;
        endcase
    end

    assign do_write = we && legal && (waddr != '0) && (32'(waddr) < NREG);

    // Set after clear so a new load to the retiring register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (do_write) begin
            busy_d[waddr] = 1'b0;
        end
        if (issue_ld && (ld_rd != '0) && (32'(ld_rd) < NREG)) begin
            busy_d[ld_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            if (do_write) begin
                regs_q[waddr] <= wv;
            end
            busy_q     <= busy_d;
            misalign_q <= we && misal;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        ra    = '0;
        rdata = '0;
        stall = 1'b0;
        for (int k = 0; k < NRP; k++) begin
            ra = raddr[k*AW +: AW];
            if ((ra != '0) && (32'(ra) < NREG)) begin
                if (BYPASS && do_write && (waddr == ra)) begin
                    rdata[k*DW +: DW] = wv;
                end else begin
                    rdata[k*DW +: DW] = regs_q[ra];
                end
                if (busy_q[ra]) begin
                    stall = 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_regfile_ext_sb.sv
// Bench for regfile_ext_sb: bypass and non-bypass instances share stimulus and are
// checked each cycle against an arithmetic model, plus hand-computed literal checks.
module tb_regfile_ext_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  wmode = '0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  byte_off = '0;
    logic [31:0] pc = '0;
    logic [9:0]  raddr = '0;
    logic        issue_ld = 1'b0;
    logic [4:0]  ld_rd = '0;

    logic [63:0] rdata_b, rdata_n;
    logic [31:0] busy_b, busy_n;
    logic        stall_b, stall_n, mis_b, mis_n;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_mis;

    regfile_ext_sb #(.DW(32), .NREG(32), .AW(5), .NRP(2), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .wmode(wmode), .waddr(waddr), .wdata(wdata),
        .byte_off(byte_off), .pc(pc), .raddr(raddr), .rdata(rdata_b),
        .issue_ld(issue_ld), .ld_rd(ld_rd), .busy(busy_b), .stall(stall_b),
        .misalign(mis_b)
    );

    regfile_ext_sb #(.DW(32), .NREG(32), .AW(5), .NRP(2), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .we(we), .wmode(wmode), .waddr(waddr), .wdata(wdata),
        .byte_off(byte_off), .pc(pc), .raddr(raddr), .rdata(rdata_n),
        .issue_ld(issue_ld), .ld_rd(ld_rd), .busy(busy_n), .stall(stall_n),
        .misalign(mis_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Write value from the mode rules, using shifts and masks on plain integers.
    function automatic logic [31:0] ext(input logic [2:0] m, input logic [31:0] d,
                                        input logic [1:0] off, input logic [31:0] p,
                                        output bit ok, output bit mis);
        int unsigned b, h;
        ok  = 1'b0;
        mis = 1'b0;
        ext = '0;
        case (m)
            3'd0: begin
                ok  = (off == 2'd0);
                mis = !ok;
                ext = d;
            end
            3'd1, 3'd2: begin
                b   = (d >> (8 * off)) & 32'hFF;
                ok  = 1'b1;
                ext = (m == 3'd1 && b >= 128) ? b - 256 : b;
            end
            3'd3, 3'd4: begin
                h   = (d >> (16 * (off / 2))) & 32'hFFFF;
                ok  = (off % 2 == 0);
                mis = !ok;
                ext = (m == 3'd3 && h >= 32768) ? h - 65536 : h;
            end
            3'd5: begin
                ok  = 1'b1;
                ext = p + 4;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        bit ok, mis;
        logic [31:0] v;
        v = ext(wmode, wdata, byte_off, pc, ok, mis);
        if (a == 0) return '0;
        if (byp && we && ok && waddr == a) return v;
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        bit ok, mis;
        logic [31:0] v;
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
            m_mis  = 1'b0;
        end else begin
            v = ext(wmode, wdata, byte_off, pc, ok, mis);
            if (we && ok && waddr != 0) begin
                m_regs[waddr] = v;
                m_busy[waddr] = 1'b0;
            end
            if (issue_ld && ld_rd != 0) m_busy[ld_rd] = 1'b1;
            m_mis = we && mis;
        end
    end

    always @(negedge clk) begin
        logic [4:0] a;
        bit st;
        if (en) begin
            st = 1'b0;
            for (int k = 0; k < 2; k++) begin
                a = raddr[k*5 +: 5];
                if (a != 0 && m_busy[a]) st = 1'b1;
                chk($sformatf("byp_rdata%0d", k), rdata_b[k*32 +: 32], exp_read(a, 1'b1));
                chk($sformatf("nobyp_rdata%0d", k), rdata_n[k*32 +: 32], exp_read(a, 1'b0));
            end
            chk("byp_busy", busy_b, m_busy);
            chk("nobyp_busy", busy_n, m_busy);
            chk("byp_stall", 32'(stall_b), 32'(st));
            chk("nobyp_stall", 32'(stall_n), 32'(st));
            chk("byp_misalign", 32'(mis_b), 32'(m_mis));
            chk("nobyp_misalign", 32'(mis_n), 32'(m_mis));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle();
        we = 1'b0; wmode = '0; waddr = '0; wdata = '0; byte_off = '0; pc = '0;
        issue_ld = 1'b0; ld_rd = '0;
    endtask

    task automatic wr(input logic [2:0] m, input logic [4:0] a, input logic [31:0] d,
                      input logic [1:0] off, input logic [31:0] p);
        we = 1'b1; wmode = m; waddr = a; wdata = d; byte_off = off; pc = p;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        en = 1'b1;

        // Reset state on every register and both ports.
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            settle();
            chk("reset_rd0", rdata_b[31:0], 32'h0);
            chk("reset_rd1", rdata_n[63:32], 32'h0);
            cyc();
        end
        settle();
        chk("reset_busy", busy_b, 32'h0);
        chk("reset_stall", 32'(stall_b), 32'h0);
        chk("reset_mis", 32'(mis_b), 32'h0);

        // Load extension.
        wr(3'd0, 5'd5, 32'h8000_00F0, 2'd0, 32'h0); cyc();
        wr(3'd1, 5'd6, 32'h8000_00F0, 2'd0, 32'h0); cyc();
        wr(3'd2, 5'd7, 32'h8000_00F0, 2'd0, 32'h0); cyc();
        wr(3'd3, 5'd8, 32'h8000_00F0, 2'd2, 32'h0); cyc();
        wr(3'd1, 5'd12, 32'h7F00_0000, 2'd3, 32'h0); cyc();
        wr(3'd4, 5'd13, 32'h9ABC_0000, 2'd2, 32'h0); cyc();
        idle();
        rd(5'd6, 5'd7); settle();
        chk("lb_r6", rdata_b[31:0], 32'hFFFF_FFF0);
        chk("lbu_r7", rdata_b[63:32], 32'h0000_00F0);
        cyc(); rd(5'd8, 5'd5); settle();
        chk("lh_r8", rdata_n[31:0], 32'hFFFF_8000);
        chk("word_r5", rdata_n[63:32], 32'h8000_00F0);
        cyc(); rd(5'd12, 5'd13); settle();
        chk("lb_off3", rdata_b[31:0], 32'h0000_007F);
        chk("lhu_off2", rdata_b[63:32], 32'h0000_9ABC);
        cyc();

        // Link write-back, including wrap.
        wr(3'd5, 5'd31, 32'hDEAD_BEEF, 2'd3, 32'h0040_0010); cyc();
        wr(3'd5, 5'd9, 32'h0, 2'd1, 32'h0040_0010); cyc();
        idle(); rd(5'd31, 5'd9); settle();
        chk("link_r31", rdata_b[31:0], 32'h0040_0014);
        chk("link_r9", rdata_b[63:32], 32'h0040_0014);
        cyc();
        wr(3'd5, 5'd31, 32'h0, 2'd0, 32'hFFFF_FFFC); cyc();
        idle(); settle();
        chk("link_wrap", rdata_b[31:0], 32'h0);
        cyc();

        // Scoreboard.
        rd(5'd4, 5'd0); issue_ld = 1'b1; ld_rd = 5'd4; settle();
        chk("sb_stall_pre", 32'(stall_b), 32'h0);
        cyc(); issue_ld = 1'b0; settle();
        chk("sb_stall_set", 32'(stall_b), 32'h1);
        chk("sb_busy4_set", 32'(busy_b[4]), 32'h1);
        cyc();
        wr(3'd0, 5'd4, 32'h44, 2'd0, 32'h0); issue_ld = 1'b1; ld_rd = 5'd4; settle();
        chk("sb_stall_bypass", 32'(stall_b), 32'h1);
        chk("sb_bypass_val", rdata_b[31:0], 32'h44);
        cyc(); idle(); settle();
        chk("sb_set_wins", 32'(busy_b[4]), 32'h1);
        cyc();
        wr(3'd0, 5'd4, 32'h55, 2'd0, 32'h0); cyc(); idle(); settle();
        chk("sb_busy4_clr", 32'(busy_b[4]), 32'h0);
        chk("sb_stall_clr", 32'(stall_b), 32'h0);
        chk("sb_r4", rdata_n[31:0], 32'h55);
        cyc();
        issue_ld = 1'b1; ld_rd = 5'd0; cyc(); idle(); settle();
        chk("sb_ld_r0", busy_b, 32'h0);
        cyc();
        issue_ld = 1'b1; ld_rd = 5'd11; cyc();
        idle(); wr(3'd0, 5'd11, 32'h1, 2'd2, 32'h0); cyc(); idle(); settle();
        chk("sb_illegal_keeps", 32'(busy_b[11]), 32'h1);
        chk("word_misalign", 32'(mis_b), 32'h1);
        cyc();

        // Bypass vs. no bypass.
        rd(5'd0, 5'd3); wr(3'd0, 5'd3, 32'h1234, 2'd0, 32'h0); settle();
        chk("byp_same_cycle", rdata_b[63:32], 32'h1234);
        chk("nobyp_same_cycle", rdata_n[63:32], 32'h0);
        cyc(); idle(); settle();
        chk("nobyp_next_cycle", rdata_n[63:32], 32'h1234);
        cyc();

        // Illegal writes, r0, reserved mode.
        wr(3'd0, 5'd2, 32'hABCD, 2'd0, 32'h0); cyc();
        wr(3'd3, 5'd2, 32'h1111_2222, 2'd1, 32'h0); cyc();
        idle(); rd(5'd2, 5'd0); settle();
        chk("lh_mis_pulse", 32'(mis_b), 32'h1);
        chk("lh_mis_nowrite", rdata_b[31:0], 32'hABCD);
        cyc(); settle();
        chk("lh_mis_gone", 32'(mis_b), 32'h0);
        cyc();
        wr(3'd0, 5'd0, 32'hFFFF, 2'd0, 32'h0); cyc(); idle(); rd(5'd0, 5'd0); settle();
        chk("r0_zero", rdata_b[31:0], 32'h0);
        cyc();
        wr(3'd6, 5'd2, 32'h7777, 2'd0, 32'h0); cyc(); idle(); rd(5'd2, 5'd0); settle();
        chk("reserved_nowrite", rdata_b[31:0], 32'hABCD);
        chk("reserved_nomis", 32'(mis_b), 32'h0);
        cyc();

        // Reset during an outstanding load drops the write in that cycle.
        issue_ld = 1'b1; ld_rd = 5'd10; cyc(); idle(); settle();
        chk("pre_rst_busy10", 32'(busy_b[10]), 32'h1);
        cyc();
        rst_n = 1'b0; wr(3'd0, 5'd5, 32'hDEAD, 2'd0, 32'h0); cyc();
        idle(); rst_n = 1'b1; rd(5'd5, 5'd10); settle();
        chk("rst_busy_clr", busy_b, 32'h0);
        chk("rst_drop_write", rdata_b[31:0], 32'h0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
